// File: rtl/line_clear_ctrl_pkg.sv
// Shared playfield types: cell colours, board dimensions and line-clear FSM states.
package line_clear_ctrl_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        CYAN   = 3'd1,
        YELLOW = 3'd2,
        PURPLE = 3'd3,
        GREEN  = 3'd4,
        RED    = 3'd5,
        BLUE   = 3'd6,
        ORANGE = 3'd7
    } block_color;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        COPY = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } lc_state_t;

endpackage

// File: rtl/line_clear_ctrl.sv
// After a piece locks: scans rows bottom-up, drops full rows, compacts the rest and blanks the top.
// Optional LINE_CLEAR_STATS_EN adds a saturating running total of cleared lines (total_lines).
module line_clear_ctrl
    import line_clear_ctrl_pkg::*;
#(
    parameter int X_SIZE = BOARD_W,
    parameter int Y_SIZE = BOARD_H
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rd_x,
    output logic [4:0]        rd_y,
    input  block_color        rd_data,
    output logic              wr_en,
    output logic [4:0]        wr_x,
    output logic [4:0]        wr_y,
    output block_color        wr_data,
    output logic [2:0]        lines_cleared,
    output logic [Y_SIZE-1:0] clear_mask
`ifdef LINE_CLEAR_STATS_EN
    ,
    output logic [15:0]       total_lines
`endif
);

    localparam logic [3:0] LAST_X  = 4'(X_SIZE - 1);
    localparam logic [3:0] DRAIN_X = 4'(X_SIZE);

    lc_state_t          state_q, state_d;
    logic [3:0]         x_q, x_d;
    logic signed [5:0]  src_q, src_d;
    logic signed [5:0]  dst_q, dst_d;
    logic signed [5:0]  dst_n;
    logic [2:0]         cnt_q, cnt_d;
    logic [Y_SIZE-1:0]  mask_q, mask_d;
    logic               full_q, full_d;
    block_color         row_q [X_SIZE];
    logic [2:0]         lines_cleared_q;
    logic [Y_SIZE-1:0]  clear_mask_q;

    // Once the last source row is handled, blank the top only if some row was removed.
    function automatic lc_state_t next_row_state(input logic signed [5:0] src,
                                                 input logic signed [5:0] dst);
        if (src != 6'sd0)
            return SCAN;
        else if (dst < 6'sd0)
            return DONE;
        else
            return FILL;
    endfunction

`ifdef LINE_CLEAR_STATS_EN
    logic [15:0] total_q;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        src_d   = src_q;
        dst_d   = dst_q;
        dst_n   = dst_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        full_d  = full_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_x    = 5'd0;
        rd_y    = 5'd0;
        wr_en   = 1'b0;
        wr_x    = 5'd0;
        wr_y    = 5'd0;
        wr_data = EMPTY;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    x_d     = 4'd0;
                    src_d   = 6'(Y_SIZE - 1);
                    dst_d   = 6'(Y_SIZE - 1);
                    cnt_d   = 3'd0;
                    mask_d  = '0;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (x_q < DRAIN_X) begin
                    rd_x = {1'b0, x_q};
                    rd_y = src_q[4:0];
                end
                // rd_data lags the address by one cycle, so cell x arrives at x_q == x+1.
                if (x_q == 4'd0)
                    full_d = 1'b1;
                else
                    full_d = full_q & (rd_data != EMPTY);
                x_d = x_q + 4'd1;
                if (x_q == DRAIN_X) begin
                    x_d = 4'd0;
                    if (full_d) begin
                        cnt_d                 = cnt_q + 3'd1;
                        mask_d[src_q[4:0]]    = 1'b1;
                    end else if (dst_q == src_q) begin
                        dst_n = dst_q - 6'sd1;
                    end
                    dst_d = dst_n;
                    if (!full_d && dst_q != src_q) begin
                        state_d = COPY;
                    end else begin
                        src_d   = src_q - 6'sd1;
                        state_d = next_row_state(src_q, dst_n);
                    end
                end
            end
            COPY: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_x    = {1'b0, x_q};
                wr_y    = dst_q[4:0];
                wr_data = row_q[x_q];
                x_d     = x_q + 4'd1;
                if (x_q == LAST_X) begin
                    x_d     = 4'd0;
                    dst_n   = dst_q - 6'sd1;
                    dst_d   = dst_n;
                    src_d   = src_q - 6'sd1;
                    state_d = next_row_state(src_q, dst_n);
                end
            end
            FILL: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                wr_x  = {1'b0, x_q};
                wr_y  = dst_q[4:0];
                x_d   = x_q + 4'd1;
                if (x_q == LAST_X) begin
                    x_d = 4'd0;
                    if (dst_q == 6'sd0)
                        state_d = DONE;
                    else
                        dst_d = dst_q - 6'sd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= IDLE;
            x_q             <= 4'd0;
            lines_cleared_q <= 3'd0;
            clear_mask_q    <= '0;
`ifdef LINE_CLEAR_STATS_EN
            total_q         <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            // Results are published as the pass enters DONE so they are valid alongside done.
            if (state_d == DONE && state_q != DONE) begin
                lines_cleared_q <= cnt_d;
                clear_mask_q    <= mask_d;
`ifdef LINE_CLEAR_STATS_EN
                total_q         <= sat_add16(total_q, cnt_d);
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        src_q  <= src_d;
        dst_q  <= dst_d;
        cnt_q  <= cnt_d;
        mask_q <= mask_d;
        full_q <= full_d;
        if (state_q == SCAN && x_q != 4'd0 && x_q <= DRAIN_X)
            row_q[x_q - 4'd1] <= rd_data;
    end

    assign lines_cleared = lines_cleared_q;
    assign clear_mask    = clear_mask_q;
`ifdef LINE_CLEAR_STATS_EN
    assign total_lines   = total_q;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: board memory model plus a row-list reference of the clear pass.
module tb_line_clear_ctrl;
    import line_clear_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        busy, done, wr_en;
    logic [4:0]  rd_x, rd_y, wr_x, wr_y;
    block_color  rd_data = EMPTY;
    block_color  wr_data;
    logic [2:0]  lines_cleared;
    logic [19:0] clear_mask;
`ifdef LINE_CLEAR_STATS_EN
    logic [15:0] total_lines;
    int          exp_total = 0;
`endif

    block_color board [BOARD_H][BOARD_W];
    int wr_cnt = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    line_clear_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_data       (wr_data),
        .lines_cleared (lines_cleared),
        .clear_mask    (clear_mask)
`ifdef LINE_CLEAR_STATS_EN
        ,
        .total_lines   (total_lines)
`endif
    );

    // Board RAM: registered read, write at the edge.
    always @(posedge Clk) begin
        if (rd_y < 5'd20 && rd_x < 5'd10)
            rd_data <= board[rd_y][rd_x[3:0]];
        else
            rd_data <= EMPTY;
        if (wr_en) begin
            if (wr_y < 5'd20 && wr_x < 5'd10)
                board[wr_y][wr_x[3:0]] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int y = 0; y < BOARD_H; y++)
            for (int x = 0; x < BOARD_W; x++)
                board[y][x] = EMPTY;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < BOARD_W; x++)
            board[y][x] = block_color'(3'($urandom_range(7, 1)));
    endtask

    // Random row guaranteed to have at least one hole.
    task automatic rand_row(input int y);
        fill_row(y);
        if ($urandom_range(3, 0) == 0) begin
            for (int x = 0; x < BOARD_W; x++) board[y][x] = EMPTY;
        end else begin
            for (int k = 0; k < int'($urandom_range(3, 1)); k++)
                board[y][$urandom_range(9, 0)] = EMPTY;
        end
    endtask

    task automatic rand_board(input int nfull);
        int y;
        for (int r = 0; r < BOARD_H; r++) rand_row(r);
        for (int k = 0; k < nfull; k++) begin
            do y = int'($urandom_range(19, 0)); while (board[y][0] != EMPTY && board[y][1] != EMPTY &&
                                                      board[y][2] != EMPTY && board[y][3] != EMPTY &&
                                                      board[y][4] != EMPTY && board[y][5] != EMPTY &&
                                                      board[y][6] != EMPTY && board[y][7] != EMPTY &&
                                                      board[y][8] != EMPTY && board[y][9] != EMPTY);
            fill_row(y);
        end
    endtask

    // Reference: keep non-full rows in order, stack them at the bottom, blank the rest.
    task automatic run_pass(input string name, input int dup_at, input bit quiet);
        block_color  exp_b [BOARD_H][BOARD_W];
        logic [19:0] emask;
        logic [29:0] ra, re;
        int nfull, copies, dsty, lowest, n, extra, exp_edges;
        bit full;
        emask  = '0;
        nfull  = 0;
        copies = 0;
        dsty   = BOARD_H - 1;
        lowest = -1;
        for (int y = BOARD_H - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < BOARD_W; x++)
                if (board[y][x] == EMPTY) full = 1'b0;
            if (full) begin
                nfull++;
                emask[y] = 1'b1;
                if (lowest < 0) lowest = y;
            end else begin
                for (int x = 0; x < BOARD_W; x++) exp_b[dsty][x] = board[y][x];
                dsty--;
                if (lowest >= 0) copies++;
            end
        end
        for (int y = dsty; y >= 0; y--)
            for (int x = 0; x < BOARD_W; x++) exp_b[y][x] = EMPTY;
        exp_edges = 221 + 10 * (copies + nfull);
`ifdef LINE_CLEAR_STATS_EN
        exp_total = (exp_total + nfull > 65535) ? 65535 : exp_total + nfull;
`endif
        wr_cnt = 0;
        start  = 1'b1;
        n      = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
            start = (n == dup_at);
            if (n == 1) check({name, ":busy_start"}, 32'(busy), 32'd1);
        end while (!done && n < exp_edges + 40);
        start = 1'b0;
        check({name, ":latency"}, 32'(n), 32'(exp_edges));
        check({name, ":done"}, 32'(done), 32'd1);
        check({name, ":busy_at_done"}, 32'(busy), 32'd0);
        check({name, ":lines"}, 32'(lines_cleared), 32'(nfull));
        check({name, ":mask"}, 32'(clear_mask), 32'(emask));
`ifdef LINE_CLEAR_STATS_EN
        check({name, ":total"}, 32'(total_lines), 32'(exp_total));
`endif
        @(posedge Clk);
        #1;
        check({name, ":done_pulse"}, 32'(done), 32'd0);
        check({name, ":held_lines"}, 32'(lines_cleared), 32'(nfull));
        if (quiet) begin
            extra = 0;
            repeat (250) begin
                @(posedge Clk);
                #1;
                if (done) extra++;
            end
            check({name, ":extra_done"}, 32'(extra), 32'd0);
        end
        check({name, ":writes"}, 32'(wr_cnt), 32'(10 * (copies + nfull)));
        for (int y = 0; y < BOARD_H; y++) begin
            for (int x = 0; x < BOARD_W; x++) begin
                ra[x*3 +: 3] = board[y][x];
                re[x*3 +: 3] = exp_b[y][x];
            end
            check($sformatf("%s:row%0d", name, y), 32'(ra), 32'(re));
        end
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        start = 1'b0;
        clear_board();
        repeat (3) @(posedge Clk);
        #1;
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:wr_en", 32'(wr_en), 32'd0);
        check("rst:rd_addr", {22'd0, rd_x, rd_y}, 32'd0);
        check("rst:wr_addr", {22'd0, wr_x, wr_y}, 32'd0);
        check("rst:wr_data", 32'(wr_data), 32'(EMPTY));
        check("rst:lines", 32'(lines_cleared), 32'd0);
        check("rst:mask", 32'(clear_mask), 32'd0);
`ifdef LINE_CLEAR_STATS_EN
        check("rst:total", 32'(total_lines), 32'd0);
`endif

        // start coincident with Reset is dropped
        start = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        start = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_start:busy", 32'(busy), 32'd0);

        // 1: empty board
        clear_board();
        run_pass("t1", -1, 1'b0);

        // 2: bottom row full, single cell above it
        clear_board();
        fill_row(19);
        board[18][3] = RED;
        run_pass("t2", -1, 1'b0);

        // 3: four full rows at the bottom
        for (int y = 0; y < 16; y++) rand_row(y);
        for (int y = 16; y < 20; y++) fill_row(y);
        run_pass("t3", -1, 1'b0);

        // 4: rows 17 and 19 full, 18 partial
        for (int y = 0; y < 20; y++) rand_row(y);
        fill_row(17);
        fill_row(19);
        run_pass("t4", -1, 1'b0);

        // 5: reset 50 cycles into a pass, then a clean pass on whatever is left
        rand_board(2);
        fill_row(19);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("t5:busy", 32'(busy), 32'd0);
        check("t5:wr_en", 32'(wr_en), 32'd0);
        check("t5:done", 32'(done), 32'd0);
        Reset = 1'b0;
`ifdef LINE_CLEAR_STATS_EN
        exp_total = 0;
`endif
        n = 0;
        repeat (20) begin
            @(posedge Clk);
            #1;
            if (done || busy) n++;
        end
        check("t5:quiet", 32'(n), 32'd0);
        run_pass("t5b", -1, 1'b0);

        // 6: second start while busy is ignored; two 2-line passes
        rand_board(2);
        run_pass("t6a", 30, 1'b1);
        rand_board(2);
        run_pass("t6b", 100, 1'b0);

        // randomized boards
        for (int i = 0; i < 6; i++) begin
            rand_board(int'($urandom_range(4, 0)));
            run_pass($sformatf("rnd%0d", i), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
